// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared constants and helpers for the ID/EX pipeline stage
package id_ex_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CTRL_W_DEF = 8;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Field offsets inside the opaque EX/MEM control bundle (consumed downstream).
  localparam int CTRL_ALU_OP_LSB  = 0;
  localparam int CTRL_ALU_OP_W    = 4;
  localparam int CTRL_ALU_SRC_BIT = 4;
  localparam int CTRL_MEM_TO_REG  = 5;
  localparam int CTRL_BRANCH_BIT  = 6;
  localparam int CTRL_JUMP_BIT    = 7;

  // True when a write-back targets a real register that matches src.
  function automatic logic wb_hits(input logic we, input logic [4:0] wreg,
                                   input logic [4:0] src);
    return we && (wreg != REG_ZERO) && (wreg == src);
  endfunction

endpackage

// File: rtl/id_ex_hazard_detect.sv
// rtl/id_ex_hazard_detect.sv - combinational load-use detection and ID stall
module id_ex_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wreg,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_stall,
  input  logic       ex_flush,
  output logic       load_use,
  output logic       id_stall
);

  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_wreg != REG_ZERO) && id_valid &&
               ((id_use_rs && (id_rs == ex_wreg)) || (id_use_rt && (id_rt == ex_wreg)));
    // Reset forces the stall low even while EX/MEM still asserts its hold.
    id_stall = !reset && (ex_stall || (load_use && !ex_flush));
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, hold refresh; optional ID_EX_HAZARD_STATS_EN counters
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_wreg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_stall,
  input  logic              ex_flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_wreg,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wreg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_bubbles,
  output logic [31:0]       stat_flushes
`endif
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, wreg_q, wreg_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              load_use;

  id_ex_hazard_detect u_hazard (
    .reset       (reset),
    .ex_valid    (valid_q),
    .ex_mem_read (mem_read_q),
    .ex_wreg     (wreg_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_stall    (ex_stall),
    .ex_flush    (ex_flush),
    .load_use    (load_use),
    .id_stall    (id_stall)
  );

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    imm_d       = imm_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    wreg_d      = wreg_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    ctrl_d      = ctrl_q;
    if (ex_flush || (!ex_stall && load_use)) begin
      // Bubbles zero the data fields too so EX never sees leftover operands.
      valid_d     = 1'b0;
      pc_d        = '0;
      rdata1_d    = '0;
      rdata2_d    = '0;
      imm_d       = '0;
      rs_d        = '0;
      rt_d        = '0;
      wreg_d      = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      ctrl_d      = '0;
    end else if (ex_stall) begin
      if (wb_hits(wb_reg_write, wb_wreg, rs_q)) rdata1_d = wb_data;
      if (wb_hits(wb_reg_write, wb_wreg, rt_q)) rdata2_d = wb_data;
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rdata1_d    = id_rdata1;
      rdata2_d    = id_rdata2;
      imm_d       = id_imm;
      rs_d        = id_rs;
      rt_d        = id_rt;
      wreg_d      = id_wreg;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
      ctrl_d      = id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wreg_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      wreg_q      <= wreg_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rdata1    = rdata1_q;
  assign ex_rdata2    = rdata2_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_wreg      = wreg_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_ctrl      = ctrl_q;

`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0] bubbles_q, bubbles_d, flushes_q, flushes_d;

  // Counters saturate rather than wrap.
  always_comb begin
    bubbles_d = bubbles_q;
    flushes_d = flushes_q;
    if (!ex_flush && !ex_stall && load_use && (bubbles_q != 32'hFFFF_FFFF))
      bubbles_d = bubbles_q + 32'd1;
    if (ex_flush && (flushes_q != 32'hFFFF_FFFF))
      flushes_d = flushes_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign stat_bubbles = bubbles_q;
  assign stat_flushes = flushes_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage, directly downstream of the register file.
- Latches register-file read data, immediate, PC and decoded control into the EX stage.
- Detects load-use hazards: stalls ID and inserts a bubble.
- Honours downstream hold (ex_stall) and branch flush (ex_flush).
- While EX is held, refreshes latched operands from write-back so held operands never go stale.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 8, width of opaque EX/MEM control bundle (ALU op, ALUSrc, etc.); passed through unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs, id_rt  in  5  source register numbers
- id_use_rs, id_use_rt  in  1  instruction actually reads rs/rt
- id_rdata1, id_rdata2  in  XLEN  register-file Read_data1/Read_data2
- id_imm  in  XLEN  extended immediate
- id_wreg  in  5  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  decoded control
- id_ctrl  in  CTRL_W  remaining control
- ex_stall  in  1  EX/MEM cannot accept; hold stage
- ex_flush  in  1  branch/jump resolved taken; kill stage contents
- wb_reg_write  in  1  write-back enable (same as register-file RegWrite)
- wb_wreg  in  5  write-back register
- wb_data  in  XLEN  write-back data
- id_stall  out  1  freeze PC and IF/ID
- ex_valid  out  1  EX holds real instruction
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  XLEN  latched fields
- ex_rs, ex_rt, ex_wreg  out  5  latched register numbers
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  latched control
- ex_ctrl  out  CTRL_W  latched control bundle

Behaviour:
- Reset (async, active-high): every registered output is 0; id_stall is 0.
- Latency: 1 cycle ID->EX.
- load_use (combinational) = ex_valid & ex_mem_read & ex_wreg!=0 & id_valid & ((id_use_rs & id_rs==ex_wreg) | (id_use_rt & id_rt==ex_wreg)).
- id_stall = ex_stall | (load_use & ~ex_flush).
- Per rising clk, priority is highest first:
  - ex_flush: bubble.
  - ex_stall: hold all fields, apply refresh.
  - load_use: bubble.
  - Otherwise: capture all id_* fields; ex_valid <= id_valid.
- Bubble: every ex_* output <= 0, including data fields (deterministic).
- Refresh during hold only:
  - If wb_reg_write & wb_wreg!=0 & wb_wreg==ex_rs: ex_rdata1 <= wb_data.
  - Same rule for ex_rt / ex_rdata2.
  - Both may update in the same cycle.
- A load_use bubble lasts exactly one cycle. The next cycle the load has left EX, load_use=0, and ID is captured.
- Register 0: never a hazard source, never refreshed.
- Invalid ID instruction (id_valid=0) captured as-is. Control bits pass through; downstream gates them with ex_valid.
- ex_flush with ex_stall: flush wins.
- Reset mid-stall: immediate clear; id_stall drops asynchronously with ex_valid.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- When defined, adds outputs stat_bubbles[31:0] and stat_flushes[31:0]:
  - stat_bubbles increments on each load_use bubble.
  - stat_flushes increments on each ex_flush cycle.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds: REG_ZERO = 5'd0, XLEN default, CTRL_W default, control-bundle field offsets.
- One sub-module: id_ex_hazard_detect (purely combinational load_use and id_stall). The pipeline register stays in id_ex_stage.

Test Plan:
1. Normal flow: id_valid=1, rs=3, rdata1=0x11, imm=0x4, no hazards -> next cycle ex_valid=1, ex_rdata1=0x11, ex_imm=0x4, id_stall=0.
2. Load-use on rt:
   - EX holds lw with ex_wreg=5, ex_mem_read=1; ID has id_rt=5, id_use_rt=1.
   - Required: id_stall=1 for one cycle; next ex_valid=0 with all fields 0.
   - Following cycle: ID captured, id_stall=0.
3. No false hazard:
   - Same as 2 but id_use_rt=0 -> no stall.
   - ex_wreg=0 -> no stall.
4. Hold with refresh:
   - ex_stall=1 for 3 cycles, ex_rs=7; wb writes reg7=0xDEAD in cycle 2.
   - Required: ex_rdata1=0xDEAD from cycle 3; other fields unchanged; id_stall=1 throughout.
5. Flush priority: ex_flush=1 with ex_stall=1 and load_use=1 -> ex_valid=0, all fields 0, id_stall=1 (from ex_stall).
6. Async reset mid-hold: reset asserted between clock edges -> all outputs 0 immediately. With ID_EX_HAZARD_STATS_EN: counters read 0; after 2 bubbles and 1 flush they read 2/1.
